// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-stepped pong controller.
// Ball and paddle motion, bounces, scoring and game FSM.
module pong_game_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int P1_X         = 16,
  parameter int P2_X         = 616,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_STEP    = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk50M,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_one_x,
  output logic [9:0] paddle_one_y,
  output logic [9:0] paddle_two_x,
  output logic [9:0] paddle_two_y,
  output logic [3:0] score_one,
  output logic [3:0] score_two,
  output logic [1:0] game_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SERVE = 2'b01,
    S_PLAY  = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0] BX0 =
    10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] BY0 =
    10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0] PY0 =
    10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0] SW   = 10'(SCREEN_W);
  localparam logic [9:0] SH   = 10'(SCREEN_H);
  localparam logic [9:0] BSZ  = 10'(BALL_SIZE);
  localparam logic [9:0] STP  = 10'(BALL_STEP);
  localparam logic [9:0] PH   = 10'(PADDLE_H);
  localparam logic [9:0] YMAX =
    10'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0] L_EDGE =
    10'(P1_X + PADDLE_W);
  localparam logic [9:0] R_EDGE = 10'(P2_X);
  localparam logic [9:0] R_SET =
    10'(P2_X - BALL_SIZE);
  localparam logic [9:0] P1X = 10'(P1_X);
  localparam logic [9:0] P2X = 10'(P2_X);
  localparam logic signed [10:0] PSTP =
    11'(PADDLE_STEP);
  localparam logic signed [10:0] PMAX =
    11'(SCREEN_H - PADDLE_H);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [CW-1:0] SLAST =
    CW'(SERVE_FRAMES - 1);

  state_t          state, state_d;
  logic            dx, dy, sdir;
  logic            dx_d, dy_d, sdir_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [9:0]      bx_d, by_d, p1_d, p2_d;
  logic [3:0]      s1_d, s2_d, s1_inc, s2_inc;
  logic            ov1, ov2, hit1, hit2;
  logic            miss_l, miss_r;
  logic            ndx, ndy;
  logic [9:0]      nx, ny;

  // Paddle step in signed 11 bits, clamped to screen
  function automatic logic [9:0] pad_next(
    input logic [9:0] y,
    input logic       up,
    input logic       dn
  );
    logic signed [10:0] t;
    t = signed'({1'b0, y});
    if (up && !dn)
      t = t - PSTP;
    else if (dn && !up)
      t = t + PSTP;
    if (t[10])
      t = '0;
    else if (t > PMAX)
      t = PMAX;
    return t[9:0];
  endfunction

  assign game_state = state;

  assign ov1 = (ball_y + BSZ > paddle_one_y) &&
               (ball_y < paddle_one_y + PH);
  assign ov2 = (ball_y + BSZ > paddle_two_y) &&
               (ball_y < paddle_two_y + PH);

  assign hit1 = !dx && ov1 &&
                (ball_x <= L_EDGE + STP) &&
                (ball_x >= L_EDGE);
  assign hit2 = dx && ov2 &&
                (ball_x + BSZ + STP >= R_EDGE) &&
                (ball_x + BSZ <= R_EDGE);

  assign miss_l = !dx && !hit1 && (ball_x < STP);
  assign miss_r = dx && !hit2 &&
                  (ball_x + BSZ + STP > SW);

  assign s1_inc = (score_one < WIN) ?
                  score_one + 4'd1 : score_one;
  assign s2_inc = (score_two < WIN) ?
                  score_two + 4'd1 : score_two;

  // Bounce resolution and ball step, both axes
  always_comb begin
    ndx = dx;
    ndy = dy;
    nx  = ball_x;
    ny  = ball_y;
    if (!dy && ball_y < STP) begin
      ndy = 1'b1;
      ny  = '0;
    end else if (dy && ball_y + BSZ + STP > SH) begin
      ndy = 1'b0;
      ny  = YMAX;
    end else begin
      ny = dy ? ball_y + STP : ball_y - STP;
    end
    if (hit1) begin
      ndx = 1'b1;
      nx  = L_EDGE;
    end else if (hit2) begin
      ndx = 1'b0;
      nx  = R_SET;
    end else begin
      nx = dx ? ball_x + STP : ball_x - STP;
    end
  end

  // Game FSM next-state and per-frame updates
  always_comb begin
    state_d = state;
    bx_d    = ball_x;
    by_d    = ball_y;
    p1_d    = paddle_one_y;
    p2_d    = paddle_two_y;
    s1_d    = score_one;
    s2_d    = score_two;
    dx_d    = dx;
    dy_d    = dy;
    sdir_d  = sdir;
    cnt_d   = cnt;
    if (frame_tick) begin
      if (state != S_OVER) begin
        p1_d = pad_next(paddle_one_y, p1_up, p1_down);
        p2_d = pad_next(paddle_two_y, p2_up, p2_down);
      end
      unique case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            s1_d    = '0;
            s2_d    = '0;
            bx_d    = BX0;
            by_d    = BY0;
            sdir_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_SERVE;
          end
        end
        S_SERVE: begin
          bx_d = BX0;
          by_d = BY0;
          if (cnt == SLAST) begin
            cnt_d   = '0;
            dx_d    = sdir;
            dy_d    = 1'b1;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        S_PLAY: begin
          bx_d = nx;
          by_d = ny;
          dx_d = ndx;
          dy_d = ndy;
          if (miss_l || miss_r) begin
            bx_d  = BX0;
            by_d  = BY0;
            cnt_d = '0;
          end
          if (miss_l) begin
            s2_d    = s2_inc;
            sdir_d  = 1'b0;
            state_d = (s2_inc == WIN) ?
                      S_OVER : S_SERVE;
          end else if (miss_r) begin
            s1_d    = s1_inc;
            sdir_d  = 1'b1;
            state_d = (s1_inc == WIN) ?
                      S_OVER : S_SERVE;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk50M or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      ball_x       <= BX0;
      ball_y       <= BY0;
      paddle_one_x <= P1X;
      paddle_two_x <= P2X;
      paddle_one_y <= PY0;
      paddle_two_y <= PY0;
      score_one    <= '0;
      score_two    <= '0;
      dx           <= 1'b1;
      dy           <= 1'b1;
      sdir         <= 1'b1;
      cnt          <= '0;
    end else begin
      state        <= state_d;
      ball_x       <= bx_d;
      ball_y       <= by_d;
      paddle_one_x <= P1X;
      paddle_two_x <= P2X;
      paddle_one_y <= p1_d;
      paddle_two_y <= p2_d;
      score_one    <= s1_d;
      score_two    <= s2_d;
      dx           <= dx_d;
      dy           <= dy_d;
      sdir         <= sdir_d;
      cnt          <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: scoreboard bench for pong_game_ctrl.
// Integer game model predicts every frame's outputs.
module tb_pong_game_ctrl;

  logic       clk50M = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       p1_up = 1'b0;
  logic       p1_down = 1'b0;
  logic       p2_up = 1'b0;
  logic       p2_down = 1'b0;
  logic [9:0] ball_x, ball_y;
  logic [9:0] paddle_one_x, paddle_one_y;
  logic [9:0] paddle_two_x, paddle_two_y;
  logic [3:0] score_one, score_two;
  logic [1:0] game_state;

  pong_game_ctrl dut (
    .clk50M(clk50M),
    .reset(reset),
    .frame_tick(frame_tick),
    .start(start),
    .p1_up(p1_up),
    .p1_down(p1_down),
    .p2_up(p2_up),
    .p2_down(p2_down),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .paddle_one_x(paddle_one_x),
    .paddle_one_y(paddle_one_y),
    .paddle_two_x(paddle_two_x),
    .paddle_two_y(paddle_two_y),
    .score_one(score_one),
    .score_two(score_two),
    .game_state(game_state)
  );

  always #5 clk50M = ~clk50M;

  typedef struct packed {
    logic [9:0] bx;
    logic [9:0] by;
    logic [9:0] px1;
    logic [9:0] p1;
    logic [9:0] px2;
    logic [9:0] p2;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;

  // Game model: state 0 idle, 1 serve, 2 play, 3 over
  int m_st, m_bx, m_by, m_dx, m_dy;
  int m_sdir, m_cnt, m_p1, m_p2, m_s1, m_s2;

  task automatic mdl_reset();
    m_st = 0;
    m_bx = 316;
    m_by = 236;
    m_dx = 1;
    m_dy = 1;
    m_sdir = 1;
    m_cnt = 0;
    m_p1 = 208;
    m_p2 = 208;
    m_s1 = 0;
    m_s2 = 0;
  endtask

  function automatic int pmove(int y, bit up, bit dn);
    int r = y;
    if (up && !dn) r = r - 4;
    if (dn && !up) r = r + 4;
    if (r < 0) r = 0;
    if (r > 416) r = 416;
    return r;
  endfunction

  task automatic new_game();
    m_s1 = 0;
    m_s2 = 0;
    m_bx = 316;
    m_by = 236;
    m_sdir = 1;
    m_cnt = 0;
    m_st = 1;
  endtask

  task automatic mdl_tick(bit st, bit u1, bit d1,
                          bit u2, bit d2);
    int os = m_st;
    int oy = m_by;
    int miss = 0;
    bit ov1 = (oy + 8 > m_p1) && (oy < m_p1 + 64);
    bit ov2 = (oy + 8 > m_p2) && (oy < m_p2 + 64);
    if (m_st == 0 || m_st == 3) begin
      if (st) new_game();
    end else if (m_st == 1) begin
      m_cnt++;
      if (m_cnt == 60) begin
        m_cnt = 0;
        m_st = 2;
        m_dx = m_sdir;
        m_dy = 1;
      end
    end else begin
      if (m_dx < 0) begin
        if (m_bx - 2 <= 24 && m_bx >= 24 && ov1) begin
          m_dx = 1;
          m_bx = 24;
        end else if (m_bx < 2) miss = 2;
        else m_bx = m_bx - 2;
      end else begin
        if (m_bx + 10 >= 616 && m_bx + 8 <= 616 &&
            ov2) begin
          m_dx = -1;
          m_bx = 608;
        end else if (m_bx + 10 > 640) miss = 1;
        else m_bx = m_bx + 2;
      end
      if (m_dy < 0 && m_by < 2) begin
        m_dy = 1;
        m_by = 0;
      end else if (m_dy > 0 && m_by + 10 > 480) begin
        m_dy = -1;
        m_by = 472;
      end else m_by = m_by + 2 * m_dy;
      if (miss != 0) begin
        m_bx = 316;
        m_by = 236;
        m_cnt = 0;
        if (miss == 1) begin
          if (m_s1 < 7) m_s1++;
          m_sdir = 1;
          m_st = (m_s1 == 7) ? 3 : 1;
        end else begin
          if (m_s2 < 7) m_s2++;
          m_sdir = -1;
          m_st = (m_s2 == 7) ? 3 : 1;
        end
      end
    end
    if (os != 3) begin
      m_p1 = pmove(m_p1, u1, d1);
      m_p2 = pmove(m_p2, u2, d2);
    end
  endtask

  function automatic exp_t mk_exp();
    exp_t e;
    e.bx = 10'(m_bx);
    e.by = 10'(m_by);
    e.px1 = 10'd16;
    e.p1 = 10'(m_p1);
    e.px2 = 10'd616;
    e.p2 = 10'(m_p2);
    e.s1 = 4'(m_s1);
    e.s2 = 4'(m_s2);
    e.st = 2'(m_st);
    return e;
  endfunction

  function automatic exp_t dut_now();
    exp_t g;
    g.bx = ball_x;
    g.by = ball_y;
    g.px1 = paddle_one_x;
    g.p1 = paddle_one_y;
    g.px2 = paddle_two_x;
    g.p2 = paddle_two_y;
    g.s1 = score_one;
    g.s2 = score_two;
    g.st = game_state;
    return g;
  endfunction

  task automatic compare(string tag, exp_t g, exp_t e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display({"FAIL %s: got bx=%0d by=%0d px1=%0d ",
                "p1=%0d px2=%0d p2=%0d s1=%0d s2=%0d ",
                "st=%0d; expected bx=%0d by=%0d px1=%0d ",
                "p1=%0d px2=%0d p2=%0d s1=%0d s2=%0d st=%0d"},
               tag, g.bx, g.by, g.px1, g.p1, g.px2,
               g.p2, g.s1, g.s2, g.st, e.bx, e.by,
               e.px1, e.p1, e.px2, e.p2, e.s1, e.s2,
               e.st);
    end
  endtask

  // Monitor: pop and compare after each frame tick
  int tick_no = 0;
  initial begin
    forever begin
      @(posedge clk50M);
      if (frame_tick === 1'b1) begin
        #1;
        tick_no++;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_empty: tick %0d, no entry",
                   tick_no);
        end else begin
          compare($sformatf("tick%0d", tick_no),
                  dut_now(), q.pop_front());
        end
      end
    end
  end

  task automatic do_tick(bit st, bit u1, bit d1,
                         bit u2, bit d2);
    @(negedge clk50M);
    start = st;
    p1_up = u1;
    p1_down = d1;
    p2_up = u2;
    p2_down = d2;
    frame_tick = 1'b1;
    mdl_tick(st, u1, d1, u2, d2);
    q.push_back(mk_exp());
    @(negedge clk50M);
    frame_tick = 1'b0;
    start = 1'($urandom);
    p1_up = 1'($urandom);
    p1_down = 1'($urandom);
    p2_up = 1'($urandom);
    p2_down = 1'($urandom);
  endtask

  function automatic bit [1:0] track(int py, int by);
    if (py + 32 < by + 2) return 2'b01;
    if (py + 32 > by + 6) return 2'b10;
    return 2'b00;
  endfunction

  task automatic rand_run(int n);
    bit trk1, trk2;
    bit [1:0] a, b;
    trk1 = 1'b0;
    trk2 = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i % 150 == 0) begin
        trk1 = ($urandom % 2) == 0;
        trk2 = ($urandom % 4) == 0;
      end
      a = trk1 ? track(m_p1, m_by) : 2'($urandom);
      b = trk2 ? track(m_p2, m_by) : 2'($urandom);
      do_tick(($urandom % 16) == 0,
              a[1], a[0], b[1], b[0]);
    end
  endtask

  initial begin
    mdl_reset();
    repeat (2) @(negedge clk50M);
    compare("por_reset", dut_now(), mk_exp());
    reset = 1'b1;

    repeat (3) do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    do_tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (59) do_tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (!(ball_x == 10'd318 && ball_y == 10'd238 &&
          paddle_one_y == 10'd0 &&
          game_state == 2'b10)) begin
      n_fail++;
      $display({"FAIL first_play: got ball=(%0d,%0d) ",
                "p1=%0d st=%0d; expected (318,238) ",
                "p1=0 st=2"},
               ball_x, ball_y, paddle_one_y, game_state);
    end

    rand_run(20);
    @(negedge clk50M);
    #2 reset = 1'b0;
    #1;
    mdl_reset();
    q.delete();
    compare("midplay_reset", dut_now(), mk_exp());
    @(negedge clk50M);
    reset = 1'b1;

    rand_run(6000);

    repeat (3) @(negedge clk50M);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d left, expected 0",
               q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
